// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// It tracks shadow copies of the register-usage fields of the instructions
// in EX and MEM. From these it drives the two ALU operand MUX4 selects and
// detects load-use hazards. On a hazard it freezes PC and IF/ID and inserts
// a bubble into ID/EX. It also keeps a saturating count of stall cycles.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          asynchronous, active-low reset
//   id_valid_i     an instruction is present in ID
//   id_rs1_i       source register 1 of the ID instruction
//   id_rs2_i       source register 2 of the ID instruction
//   id_rd_i        destination register of the ID instruction
//   id_regwrite_i  the ID instruction writes rd
//   id_memread_i   the ID instruction is a load
//   id_alusrc_i    ALU operand B is the immediate
//   flush_i        kill the ID instruction (taken branch)
//   stall_o        hold PC and IF/ID this cycle (combinational)
//   bubble_o       zero the ID/EX control fields at this edge
//   fwd_a_o        operand-A MUX4 select, valid during the EX cycle
//   fwd_b_o        operand-B MUX4 select, valid during the EX cycle
//   stall_cnt_o    saturating count of stall cycles
//
// Select encoding: 00 ID/EX register data, 01 MEM/WB write-back data,
// 10 EX/MEM ALU result, 11 immediate (operand B only).
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_alusrc_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_WB    = 2'b01,
        SEL_EXMEM = 2'b10,
        SEL_IMM   = 2'b11
    } fwd_sel_e;

    // EX-stage record; memread is kept here because only a load sitting in
    // EX can cause a stall.
    logic              exValid_q,    exValid_d;
    logic [REG_AW-1:0] exRd_q,       exRd_d;
    logic              exRegwrite_q, exRegwrite_d;
    logic              exMemread_q,  exMemread_d;

    // MEM-stage record. The WB-stage instruction needs no shadow: its result
    // reaches ID through the register file's write-then-read path, so nothing
    // here ever selects it.
    logic              memValid_q;
    logic [REG_AW-1:0] memRd_q;
    logic              memRegwrite_q;

    fwd_sel_e          fwdA_q, fwdA_d;
    fwd_sel_e          fwdB_q, fwdB_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic              advance;
    logic              exWritesRs1, exWritesRs2;
    logic              memWritesRs1, memWritesRs2;

    // A load in EX whose result the ID instruction needs. Operand B only
    // matters when it is not replaced by the immediate. Flush wins.
    assign stall_o = id_valid_i & ~flush_i & exValid_q & exMemread_q
                   & (exRd_q != '0)
                   & ((exRd_q == id_rs1_i) | (~id_alusrc_i & (exRd_q == id_rs2_i)));

    assign bubble_o = stall_o | flush_i;
    assign advance  = id_valid_i & ~flush_i & ~stall_o;

    // EX/MEM forwarding excludes loads: their data is not ready yet, and the
    // stall above guarantees the consumer is re-evaluated once the load is
    // in MEM. x0 is never a forwarding source.
    assign exWritesRs1  = exValid_q & exRegwrite_q & ~exMemread_q
                        & (exRd_q != '0) & (exRd_q == id_rs1_i);
    assign exWritesRs2  = exValid_q & exRegwrite_q & ~exMemread_q
                        & (exRd_q != '0) & (exRd_q == id_rs2_i);
    assign memWritesRs1 = memValid_q & memRegwrite_q
                        & (memRd_q != '0) & (memRd_q == id_rs1_i);
    assign memWritesRs2 = memValid_q & memRegwrite_q
                        & (memRd_q != '0) & (memRd_q == id_rs2_i);

    // Next EX record and operand selects for the instruction entering EX.
    // The newest producer wins; a bubble entering EX gets 00 selects.
    always_comb begin
        exValid_d    = 1'b0;
        exRd_d       = '0;
        exRegwrite_d = 1'b0;
        exMemread_d  = 1'b0;
        fwdA_d       = SEL_REG;
        fwdB_d       = SEL_REG;
        stallCnt_d   = stallCnt_q;

        if (advance) begin
            exValid_d    = 1'b1;
            exRd_d       = id_rd_i;
            exRegwrite_d = id_regwrite_i;
            exMemread_d  = id_memread_i;

            if (exWritesRs1)       fwdA_d = SEL_EXMEM;
            else if (memWritesRs1) fwdA_d = SEL_WB;

            if (id_alusrc_i)       fwdB_d = SEL_IMM;
            else if (exWritesRs2)  fwdB_d = SEL_EXMEM;
            else if (memWritesRs2) fwdB_d = SEL_WB;
        end

        if (stall_o && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Pipeline shadow registers, select registers and stall counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exValid_q     <= 1'b0;
            exRd_q        <= '0;
            exRegwrite_q  <= 1'b0;
            exMemread_q   <= 1'b0;
            memValid_q    <= 1'b0;
            memRd_q       <= '0;
            memRegwrite_q <= 1'b0;
            fwdA_q        <= SEL_REG;
            fwdB_q        <= SEL_REG;
            stallCnt_q    <= '0;
        end else begin
            exValid_q     <= exValid_d;
            exRd_q        <= exRd_d;
            exRegwrite_q  <= exRegwrite_d;
            exMemread_q   <= exMemread_d;
            memValid_q    <= exValid_q;
            memRd_q       <= exRd_q;
            memRegwrite_q <= exRegwrite_q;
            fwdA_q        <= fwdA_d;
            fwdB_q        <= fwdB_d;
            stallCnt_q    <= stallCnt_d;
        end
    end

    assign fwd_a_o     = fwdA_q;
    assign fwd_b_o     = fwdB_q;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Scoreboard bench for fwd_hazard_ctrl. Each directed ID-stage vector is
// driven on a falling edge together with its hand-computed expectations:
// stall/bubble for that cycle, and selects/counter after the next rising
// edge. A separate monitor pops those expectations and compares. The
// counter is built 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rstN;
    logic              idValid;
    logic [REG_AW-1:0] idRs1, idRs2, idRd;
    logic              idRegwrite, idMemread, idAlusrc, flush;
    logic              stall, bubble;
    logic [1:0]        fwdA, fwdB;
    logic [CNT_W-1:0]  stallCnt;

    typedef struct {
        int               idx;
        logic             stall;
        logic             bubble;
        logic [1:0]       fwdA;
        logic [1:0]       fwdB;
        logic [CNT_W-1:0] cnt;
    } expItem_t;

    expItem_t sbQ[$];
    int       assertCount = 0;
    int       failCount   = 0;
    int       expCnt      = 0;
    int       vecIdx      = 0;
    bit       monBusy     = 1'b0;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rstN),
        .id_valid_i   (idValid),
        .id_rs1_i     (idRs1),
        .id_rs2_i     (idRs2),
        .id_rd_i      (idRd),
        .id_regwrite_i(idRegwrite),
        .id_memread_i (idMemread),
        .id_alusrc_i  (idAlusrc),
        .flush_i      (flush),
        .stall_o      (stall),
        .bubble_o     (bubble),
        .fwd_a_o      (fwdA),
        .fwd_b_o      (fwdB),
        .stall_cnt_o  (stallCnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Shared compare: counts every comparison and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one ID-stage vector on the falling edge and queue what the DUT
    // must show for it. The counter expectation is a saturating tally of
    // the hand-given stall values.
    task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rs1,
                                 input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                                 input logic rw, input logic mr, input logic alu,
                                 input logic fl, input logic eStall, input logic eBubble,
                                 input logic [1:0] eA, input logic [1:0] eB);
        expItem_t item;
        @(negedge clk);
        idValid    = v;
        idRs1      = rs1;
        idRs2      = rs2;
        idRd       = rd;
        idRegwrite = rw;
        idMemread  = mr;
        idAlusrc   = alu;
        flush      = fl;
        if (eStall && expCnt < CNT_MAX) expCnt++;
        vecIdx++;
        item.idx    = vecIdx;
        item.stall  = eStall;
        item.bubble = eBubble;
        item.fwdA   = eA;
        item.fwdB   = eB;
        item.cnt    = expCnt[CNT_W-1:0];
        sbQ.push_back(item);
    endtask

    task automatic setIdle();
        idValid    = 1'b0;
        idRs1      = '0;
        idRs2      = '0;
        idRd       = '0;
        idRegwrite = 1'b0;
        idMemread  = 1'b0;
        idAlusrc   = 1'b0;
        flush      = 1'b0;
    endtask

    // Wait, bounded, for the monitor to consume every queued expectation.
    task automatic drainQueue();
        for (int i = 0; i < 20 && (sbQ.size() > 0 || monBusy); i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(sbQ.size()) + 32'(monBusy), 32'd0);
    endtask

    // Monitor: combinational outputs are sampled mid low phase, registered
    // outputs one unit after the following rising edge.
    initial begin
        expItem_t item;
        forever begin
            @(negedge clk);
            #2;
            if (sbQ.size() > 0) begin
                monBusy = 1'b1;
                item = sbQ.pop_front();
                checkOutput($sformatf("stall#%0d", item.idx), 32'(stall), 32'(item.stall));
                checkOutput($sformatf("bubble#%0d", item.idx), 32'(bubble), 32'(item.bubble));
                @(posedge clk);
                #1;
                checkOutput($sformatf("fwd_a#%0d", item.idx), 32'(fwdA), 32'(item.fwdA));
                checkOutput($sformatf("fwd_b#%0d", item.idx), 32'(fwdB), 32'(item.fwdB));
                checkOutput($sformatf("stall_cnt#%0d", item.idx), 32'(stallCnt), 32'(item.cnt));
                monBusy = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setIdle();
        rstN = 1'b0;
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_bubble", 32'(bubble), 32'd0);
        checkOutput("reset_fwd_a", 32'(fwdA), 32'd0);
        checkOutput("reset_fwd_b", 32'(fwdB), 32'd0);
        checkOutput("reset_cnt", 32'(stallCnt), 32'd0);
        flush = 1'b1;
        #1;
        checkOutput("reset_bubble_follows_flush", 32'(bubble), 32'd1);
        flush = 1'b0;
        @(negedge clk);
        rstN = 1'b1;

        //             v  rs1 rs2 rd  rw mr alu fl  stl bub fwdA   fwdB
        // ALU dependency: add x5 then sub x8, x5
        applyStimulus(1,  1,  2,  5,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  5,  6,  8,  1, 0, 0,  0,  0,  0,  2'b10, 2'b00);
        // Distance 2: add x5, nop, or rs2=x5
        applyStimulus(1,  0,  0,  5,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  9,  5,  10, 1, 0, 0,  0,  0,  0,  2'b00, 2'b01);
        // Same but operand B is the immediate
        applyStimulus(1,  0,  0,  5,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  9,  5,  11, 1, 0, 1,  0,  0,  0,  2'b00, 2'b11);
        // Load-use on rs1: lw x7, then add x13, x7 stalls once
        applyStimulus(1,  9,  0,  7,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        applyStimulus(1,  7,  12, 13, 1, 0, 0,  0,  1,  1,  2'b00, 2'b00);
        applyStimulus(1,  7,  12, 13, 1, 0, 0,  0,  0,  0,  2'b01, 2'b00);
        // Two writers of x3 back to back, then a reader: newest wins
        applyStimulus(1,  0,  0,  3,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  0,  0,  3,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  3,  3,  14, 1, 0, 0,  0,  0,  0,  2'b10, 2'b10);
        // Writers of x0 (including lw x0) never forward or stall
        applyStimulus(1,  0,  0,  0,  1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        applyStimulus(1,  0,  0,  0,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        applyStimulus(1,  0,  0,  15, 1, 0, 0,  0,  0,  0,  2'b00, 2'b00);
        // Flush over stall: lw x7, then a dependent add flushed
        applyStimulus(1,  0,  0,  7,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        applyStimulus(1,  7,  0,  16, 1, 0, 0,  1,  0,  1,  2'b00, 2'b00);
        applyStimulus(1,  7,  7,  17, 1, 0, 0,  0,  0,  0,  2'b01, 2'b01);
        // rs2 matching a load is ignored when operand B is the immediate
        applyStimulus(1,  0,  0,  8,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        applyStimulus(1,  0,  8,  18, 1, 0, 1,  0,  0,  0,  2'b00, 2'b11);
        // Load-use on rs2 with a register operand B
        applyStimulus(1,  0,  0,  9,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        applyStimulus(1,  1,  9,  19, 1, 0, 0,  0,  1,  1,  2'b00, 2'b00);
        applyStimulus(1,  1,  9,  19, 1, 0, 0,  0,  0,  0,  2'b00, 2'b01);
        // Load into EX ahead of the mid-stall reset
        applyStimulus(1,  0,  0,  7,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        drainQueue();

        // Reset asserted while a load-use stall is active
        @(negedge clk);
        idValid = 1'b1; idRs1 = 5'd7; idRs2 = 5'd0; idRd = 5'd20;
        idRegwrite = 1'b1; idMemread = 1'b0; idAlusrc = 1'b0; flush = 1'b0;
        #2;
        checkOutput("midstall_stall_before_reset", 32'(stall), 32'd1);
        checkOutput("midstall_cnt_before_reset", 32'(stallCnt), 32'd2);
        rstN = 1'b0;
        #1;
        checkOutput("midstall_reset_stall", 32'(stall), 32'd0);
        checkOutput("midstall_reset_bubble", 32'(bubble), 32'd0);
        checkOutput("midstall_reset_fwd_b", 32'(fwdB), 32'd0);
        checkOutput("midstall_reset_cnt", 32'(stallCnt), 32'd0);
        expCnt = 0;
        @(negedge clk);
        setIdle();
        rstN = 1'b1;

        // Saturation: chained lw x7, 0(x7) stalls every other cycle
        applyStimulus(1,  7,  0,  7,  1, 1, 1,  0,  0,  0,  2'b00, 2'b11);
        for (int i = 1; i <= 40; i++) begin
            if (i % 2 == 1)
                applyStimulus(1, 7, 0, 7, 1, 1, 1, 0, 1, 1, 2'b00, 2'b00);
            else
                applyStimulus(1, 7, 0, 7, 1, 1, 1, 0, 0, 0, 2'b01, 2'b11);
        end
        @(negedge clk);
        setIdle();
        drainQueue();
        checkOutput("saturated_cnt", 32'(stallCnt), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
